regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with a separate PC register. Successor to the core's single-write, two-read register file.
- Adds configurable read/write port counts, optional write-to-read bypass, and a per-register pending scoreboard so decode can tell when an operand is still in flight.
- Sits between decode (read, issue) and writeback (write). PC write/read semantics match the existing core.

Parameters:
XLEN, 32, data and PC width
NREGS, 32, number of architectural registers (power of 2, >=2); register 0 hardwired to zero
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
PC_INIT  in  XLEN  PC value loaded on reset
RADR_SD  in  NRD*AW  read addresses, port i at [i*AW +: AW]
RDATA_SR  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
RVALID_SR  out  NRD  1 = operand i not pending (or bypassed this cycle)
WADR_SW  in  NWR*AW  write addresses
WDATA_SW  in  NWR*XLEN  write data
WENABLE_SW  in  NWR  per-port write enable
ISSUE_ADR_SD  in  AW  destination register of instruction issued this cycle
ISSUE_EN_SD  in  1  mark ISSUE_ADR_SD pending
WRITE_PC_SD  in  XLEN  next PC
WRITE_PC_ENABLE_SD  in  1  PC write enable
READ_PC_SR  out  XLEN  current PC
PENDING_CNT_SR  out  $clog2(NREGS+1)  number of registers currently pending

Behaviour:
- One clock domain, clk rising edge. Reset is synchronous, active-high.
- Reset: at the first clk edge with reset=1:
  - all registers = 0;
  - all pending bits = 0;
  - PC = PC_INIT.
- Reset dominates every write, issue and PC update on the same edge.
- Outputs after reset, with no stimulus:
  - RDATA_SR = 0;
  - RVALID_SR = all 1s;
  - READ_PC_SR = PC_INIT;
  - PENDING_CNT_SR = 0.
- Before the first reset edge all outputs are undefined.
- Register 0:
  - reads always return 0 with RVALID = 1;
  - writes are ignored;
  - issue to register 0 is ignored (never pending).
- Writes:
  - port j updates register WADR[j] at the edge when WENABLE[j]=1 and WADR[j]!=0;
  - several enabled ports may target the same address; the highest port index wins;
  - write latency is 1 cycle (visible on a read the cycle after the edge).
- Reads:
  - combinational from the array, 0-cycle latency;
  - all NRD ports are independent and may share an address.
- Bypass (BYPASS=1):
  - if any enabled write port targets RADR[i] (!=0) in the same cycle, RDATA[i] = that port's WDATA (highest index among matches) and RVALID[i] = 1;
  - with BYPASS=0, RDATA[i] is the array value and RVALID[i] follows pending only.
- Scoreboard (1 bit per register):
  - ISSUE_EN sets pending[ISSUE_ADR] at the edge;
  - an enabled write to register r clears pending[r] at the edge;
  - issue and write to the same r on the same edge: data is written and pending stays 1 (the newer producer is in flight);
  - issue to an already-pending register: remains 1, no count;
  - RVALID[i] = ~pending[RADR[i]] | bypass_hit[i].
- PENDING_CNT_SR is a combinational popcount of the pending bits; range 0..NREGS-1.
- PC:
  - WRITE_PC_ENABLE_SD=1 loads WRITE_PC_SD at the edge;
  - READ_PC_SR is the registered value, with no bypass;
  - the PC is independent of the general write ports; there is no shared address alias.
- Reset asserted mid-operation: pending writes and issues on that edge are discarded; state returns to reset values at that edge.

Test Plan:
- Reset with PC_INIT=0x0000_1000, hold 1 cycle, deassert -> READ_PC_SR=0x1000, all RDATA=0, RVALID all 1, PENDING_CNT=0.
- Write port0 r5=0xDEAD_BEEF, next cycle read r5 on both ports -> 0xDEADBEEF, RVALID=11. Write r0=0x1234 -> r0 still reads 0.
- Same cycle: port0 and port1 both write r7 (0x11, 0x22) with read r7 (BYPASS=1) -> RDATA=0x22 that cycle and after the edge. With BYPASS=0, the read that cycle shows the old value.
- Issue r3 -> next cycle RVALID for r3 = 0, PENDING_CNT=1. Write r3=0x55 -> same cycle RVALID=1 via bypass; after the edge pending cleared, count=0.
- Issue r4 and write r4=0x77 on the same edge -> r4 reads 0x77, still pending (RVALID=0), count=1. Then assert reset -> count=0, r4=0, PC=PC_INIT.
- WRITE_PC_ENABLE_SD=1 with WRITE_PC_SD=0x2000 while port1 writes r31=0x9 -> next cycle PC=0x2000 and r31=0x9. With enable=0, PC holds.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with PC register, optional write-to-read
// forwarding and a per-register pending scoreboard for in-flight operands.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     PC_INIT,
    input  logic [NRD*AW-1:0]   RADR_SD,
    output logic [NRD*XLEN-1:0] RDATA_SR,
    output logic [NRD-1:0]      RVALID_SR,
    input  logic [NWR*AW-1:0]   WADR_SW,
    input  logic [NWR*XLEN-1:0] WDATA_SW,
    input  logic [NWR-1:0]      WENABLE_SW,
    input  logic [AW-1:0]       ISSUE_ADR_SD,
    input  logic                ISSUE_EN_SD,
    input  logic [XLEN-1:0]     WRITE_PC_SD,
    input  logic                WRITE_PC_ENABLE_SD,
    output logic [XLEN-1:0]     READ_PC_SR,
    output logic [CW-1:0]       PENDING_CNT_SR
);

    logic [XLEN-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] pending_reg;
    logic [XLEN-1:0] pc_reg;

    // Ports are applied in ascending order so the highest index wins a
    // same-address collision; issue is applied last so a new producer issued
    // on the same edge as a write keeps the register pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
            pending_reg <= '0;
            pc_reg      <= PC_INIT;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (WENABLE_SW[j] && (WADR_SW[j*AW +: AW] != '0)) begin
                    regs_reg[WADR_SW[j*AW +: AW]]    <= WDATA_SW[j*XLEN +: XLEN];
                    pending_reg[WADR_SW[j*AW +: AW]] <= 1'b0;
                end
            end
            if (ISSUE_EN_SD && (ISSUE_ADR_SD != '0)) begin
                pending_reg[ISSUE_ADR_SD] <= 1'b1;
            end
            if (WRITE_PC_ENABLE_SD) begin
                pc_reg <= WRITE_PC_SD;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_read
            logic [AW-1:0]   radr;
            logic            hit;
            logic [XLEN-1:0] byp_data;

            assign radr = RADR_SD[gi*AW +: AW];

            always_comb begin
                hit      = 1'b0;
                byp_data = '0;
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (WENABLE_SW[j] && (WADR_SW[j*AW +: AW] == radr) && (radr != '0)) begin
                            hit      = 1'b1;
                            byp_data = WDATA_SW[j*XLEN +: XLEN];
                        end
                    end
                end
            end

            assign RDATA_SR[gi*XLEN +: XLEN] = (radr == '0) ? '0 :
                                               (hit ? byp_data : regs_reg[radr]);
            assign RVALID_SR[gi] = (radr == '0) | ~pending_reg[radr] | hit;
        end
    endgenerate

    always_comb begin
        PENDING_CNT_SR = '0;
        for (int r = 0; r < NREGS; r++) begin
            PENDING_CNT_SR = PENDING_CNT_SR + CW'(pending_reg[r]);
        end
    end

    assign READ_PC_SR = pc_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: forwarding and non-forwarding instances share
// stimulus; expected values are queued at drive time and checked mid-cycle.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_init;
    logic [AW-1:0]   radr0, radr1;
    logic [2*AW-1:0] radr;
    logic [AW-1:0]   wadr0, wadr1;
    logic [XLEN-1:0] wdata0, wdata1;
    logic [1:0]      wen;
    logic [AW-1:0]   issue_adr;
    logic            issue_en;
    logic [XLEN-1:0] write_pc;
    logic            write_pc_en;

    logic [2*XLEN-1:0] rdata, nb_rdata;
    logic [1:0]        rvalid, nb_rvalid;
    logic [XLEN-1:0]   pc, nb_pc;
    logic [CW-1:0]     cnt, nb_cnt;

    assign radr = {radr1, radr0};

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .PC_INIT(pc_init),
        .RADR_SD(radr), .RDATA_SR(rdata), .RVALID_SR(rvalid),
        .WADR_SW({wadr1, wadr0}), .WDATA_SW({wdata1, wdata0}), .WENABLE_SW(wen),
        .ISSUE_ADR_SD(issue_adr), .ISSUE_EN_SD(issue_en),
        .WRITE_PC_SD(write_pc), .WRITE_PC_ENABLE_SD(write_pc_en),
        .READ_PC_SR(pc), .PENDING_CNT_SR(cnt)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .PC_INIT(pc_init),
        .RADR_SD(radr), .RDATA_SR(nb_rdata), .RVALID_SR(nb_rvalid),
        .WADR_SW({wadr1, wadr0}), .WDATA_SW({wdata1, wdata0}), .WENABLE_SW(wen),
        .ISSUE_ADR_SD(issue_adr), .ISSUE_EN_SD(issue_en),
        .WRITE_PC_SD(write_pc), .WRITE_PC_ENABLE_SD(write_pc_en),
        .READ_PC_SR(nb_pc), .PENDING_CNT_SR(nb_cnt)
    );

    typedef struct {
        int          sel;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int S_RD0 = 0, S_RD1 = 1, S_RV = 2, S_PC = 3, S_CNT = 4,
                   S_NB_RD0 = 5, S_NB_RV = 6, S_NB_PC = 7, S_NB_CNT = 8;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD0:    return rdata[31:0];
            S_RD1:    return rdata[63:32];
            S_RV:     return {30'd0, rvalid};
            S_PC:     return pc;
            S_CNT:    return {26'd0, cnt};
            S_NB_RD0: return nb_rdata[31:0];
            S_NB_RV:  return {30'd0, nb_rvalid};
            S_NB_PC:  return nb_pc;
            S_NB_CNT: return {26'd0, nb_cnt};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.sel = sel;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Sample mid-cycle, well away from the rising edge.
    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #4;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic next_step();
        @(posedge clk);
        #1;
        wen         = 2'b00;
        wadr0       = '0;
        wadr1       = '0;
        wdata0      = '0;
        wdata1      = '0;
        issue_en    = 1'b0;
        issue_adr   = '0;
        write_pc_en = 1'b0;
        write_pc    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc_init = 32'h0000_1000;
        radr0 = 5'd5; radr1 = 5'd0;
        wen = 2'b00; wadr0 = '0; wadr1 = '0; wdata0 = '0; wdata1 = '0;
        issue_en = 1'b0; issue_adr = '0; write_pc_en = 1'b0; write_pc = '0;

        // Reset state
        next_step();
        reset = 1'b0;
        expect_val(S_PC, 32'h1000, "reset_pc");
        expect_val(S_NB_PC, 32'h1000, "reset_pc_nb");
        expect_val(S_RD0, 32'h0, "reset_rd0");
        expect_val(S_RD1, 32'h0, "reset_rd1");
        expect_val(S_RV, 32'h3, "reset_rvalid");
        expect_val(S_CNT, 32'h0, "reset_cnt");
        expect_val(S_NB_CNT, 32'h0, "reset_cnt_nb");
        check_all();

        // Write r5, forwarded same cycle only with bypass
        next_step();
        wen = 2'b01; wadr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; radr0 = 5'd5; radr1 = 5'd5;
        expect_val(S_RD0, 32'hDEAD_BEEF, "r5_bypass");
        expect_val(S_NB_RD0, 32'h0, "r5_nobypass_old");
        check_all();
        next_step();
        expect_val(S_RD0, 32'hDEAD_BEEF, "r5_rd0");
        expect_val(S_RD1, 32'hDEAD_BEEF, "r5_rd1");
        expect_val(S_RV, 32'h3, "r5_rvalid");
        expect_val(S_NB_RD0, 32'hDEAD_BEEF, "r5_nb_rd0");
        check_all();

        // r0 is hardwired to zero
        next_step();
        wen = 2'b01; wadr0 = 5'd0; wdata0 = 32'h1234; radr0 = 5'd0;
        expect_val(S_RD0, 32'h0, "r0_write_bypass");
        check_all();
        next_step();
        expect_val(S_RD0, 32'h0, "r0_read");
        expect_val(S_RV, 32'h3, "r0_rvalid");
        check_all();

        // Two ports write r7: higher index wins
        next_step();
        wen = 2'b11; wadr0 = 5'd7; wdata0 = 32'h11; wadr1 = 5'd7; wdata1 = 32'h22;
        radr0 = 5'd7; radr1 = 5'd7;
        expect_val(S_RD0, 32'h22, "r7_bypass_prio");
        expect_val(S_RD1, 32'h22, "r7_bypass_prio1");
        expect_val(S_NB_RD0, 32'h0, "r7_nobypass_old");
        check_all();
        next_step();
        expect_val(S_RD0, 32'h22, "r7_after");
        expect_val(S_NB_RD0, 32'h22, "r7_nb_after");
        check_all();

        // Issue r3, then clear it with a write
        next_step();
        issue_en = 1'b1; issue_adr = 5'd3; radr0 = 5'd3; radr1 = 5'd0;
        expect_val(S_RV, 32'h3, "issue_r3_same");
        expect_val(S_CNT, 32'h0, "issue_r3_cnt_same");
        check_all();
        next_step();
        expect_val(S_RV, 32'h2, "r3_pending");
        expect_val(S_CNT, 32'h1, "r3_cnt");
        check_all();
        next_step();
        wen = 2'b10; wadr1 = 5'd3; wdata1 = 32'h55;
        expect_val(S_RV, 32'h3, "r3_bypass_valid");
        expect_val(S_RD0, 32'h55, "r3_bypass_data");
        expect_val(S_NB_RV, 32'h2, "r3_nb_still_pending");
        expect_val(S_NB_RD0, 32'h0, "r3_nb_old");
        check_all();
        next_step();
        expect_val(S_RV, 32'h3, "r3_cleared");
        expect_val(S_CNT, 32'h0, "r3_cnt_cleared");
        expect_val(S_RD0, 32'h55, "r3_data");
        check_all();

        // Issue and write r4 on the same edge: data lands, stays pending
        next_step();
        issue_en = 1'b1; issue_adr = 5'd4; wen = 2'b01; wadr0 = 5'd4; wdata0 = 32'h77;
        radr0 = 5'd4;
        expect_val(S_RD0, 32'h77, "r4_bypass");
        check_all();
        next_step();
        expect_val(S_RD0, 32'h77, "r4_data");
        expect_val(S_RV, 32'h2, "r4_pending");
        expect_val(S_CNT, 32'h1, "r4_cnt");
        check_all();
        // Re-issue an already pending register: count unchanged
        next_step();
        issue_en = 1'b1; issue_adr = 5'd4;
        check_all();
        next_step();
        issue_en = 1'b1; issue_adr = 5'd9;
        expect_val(S_CNT, 32'h1, "r4_reissue_cnt");
        check_all();
        next_step();
        expect_val(S_CNT, 32'h2, "r9_issue_cnt");
        expect_val(S_NB_CNT, 32'h2, "r9_issue_cnt_nb");
        check_all();

        // Reset dominates write, issue and PC update on the same edge
        next_step();
        reset = 1'b1;
        wen = 2'b01; wadr0 = 5'd6; wdata0 = 32'hAA;
        issue_en = 1'b1; issue_adr = 5'd6;
        write_pc_en = 1'b1; write_pc = 32'h5000;
        check_all();
        next_step();
        reset = 1'b0; radr0 = 5'd4; radr1 = 5'd6;
        expect_val(S_RD0, 32'h0, "rst_r4");
        expect_val(S_RD1, 32'h0, "rst_r6");
        expect_val(S_RV, 32'h3, "rst_rvalid");
        expect_val(S_CNT, 32'h0, "rst_cnt");
        expect_val(S_PC, 32'h1000, "rst_pc");
        check_all();

        // PC write alongside a port1 write to r31
        next_step();
        write_pc_en = 1'b1; write_pc = 32'h2000;
        wen = 2'b10; wadr1 = 5'd31; wdata1 = 32'h9; radr1 = 5'd31;
        expect_val(S_PC, 32'h1000, "pc_no_bypass");
        expect_val(S_RD1, 32'h9, "r31_bypass");
        check_all();
        next_step();
        write_pc_en = 1'b0; write_pc = 32'h3000;
        expect_val(S_PC, 32'h2000, "pc_loaded");
        expect_val(S_RD1, 32'h9, "r31_data");
        check_all();
        next_step();
        expect_val(S_PC, 32'h2000, "pc_hold");
        expect_val(S_NB_PC, 32'h2000, "pc_hold_nb");
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
